// File: rtl/seq_signed_mpy.sv
`default_nettype none
// ============================================================================
//  Module   : seq_signed_mpy
//  Purpose  : Multi-cycle shift-add multiplier, one multiplier bit per clock.
//             sgn=1 treats a/b as two's complement (MSB of b carries negative
//             weight), sgn=0 treats them as unsigned. start/busy/done handshake.
//  Options  : SEQ_MPY_ACC_EN - adds acc_clr input; product accumulates
//             (product = (acc_clr ? 0 : product) + a*b) on each completion.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_signed_mpy #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           sgn,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
`ifdef SEQ_MPY_ACC_EN
    input  logic           acc_clr,
`endif
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [2*W-1:0]   mcand;      // a_ext << step, shifted left every step
    logic [W-1:0]     mplier;     // remaining multiplier bits, LSB is current
    logic             sgn_q;
    logic [2*W-1:0]   acc;
    logic [CW-1:0]    cnt;
`ifdef SEQ_MPY_ACC_EN
    logic             acc_clr_q;
`endif

    logic             accept;
    logic [2*W-1:0]   a_ext;
    logic [2*W-1:0]   addend;
    logic [2*W-1:0]   acc_next;

    // Operand extension, and the single shared add/subtract of the current step.
    // The last step of a signed operation subtracts: the multiplier MSB has weight -2^(W-1).
    always_comb begin
        accept   = start && (state != RUN);
        a_ext    = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        addend   = mplier[0] ? mcand : '0;
        acc_next = (sgn_q && (cnt == LAST_STEP)) ? (acc - addend) : (acc + addend);
    end

    // Control FSM and datapath registers; product is written only on the completing step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            product   <= '0;
            mcand     <= '0;
            mplier    <= '0;
            sgn_q     <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
`ifdef SEQ_MPY_ACC_EN
            acc_clr_q <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_STEP) begin
`ifdef SEQ_MPY_ACC_EN
                        product <= (acc_clr_q ? '0 : product) + acc_next;
`else
                        product <= acc_next;
`endif
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; done is a single-cycle pulse.
                    done <= 1'b0;
                    if (accept) begin
                        mcand     <= a_ext;
                        mplier    <= b;
                        sgn_q     <= sgn;
                        acc       <= '0;
                        cnt       <= '0;
`ifdef SEQ_MPY_ACC_EN
                        acc_clr_q <= acc_clr;
`endif
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
